// File: rtl/traffic_light_fsm.sv
// Main sequencing controller of the traffic light controller.
// Walks the main/side light cycle, starts the interval timer on every phase
// change, stretches green phases on the side-street sensor and inserts a
// pedestrian walk phase when a walk request has been latched.
module traffic_light_fsm #(
  parameter logic [1:0] SEL_BASE = 2'b00,
  parameter logic [1:0] SEL_EXT  = 2'b01,
  parameter logic [1:0] SEL_YEL  = 2'b10
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       reprogram,
  input  logic       expired,
  output logic       start_timer,
  output logic [1:0] interval_sel,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp
);

  // Light vectors are {red, yellow, green}; exactly one bit is ever set.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [2:0] {
    S_MG1,
    S_MGX,
    S_MY,
    S_WALK,
    S_SG,
    S_SGX,
    S_SY
  } state_t;

  state_t     r_state;
  logic       r_mgx_ext;        // MGX runs the extended interval
  logic       r_walk_latch;
  logic       r_start_pending;  // restart pulse owed after reset/reprogram
  logic       r_start_timer;
  logic [1:0] r_interval_sel;
  logic [2:0] r_main_lights;
  logic [2:0] r_side_lights;
  logic       r_walk_lamp;

  logic       w_take;
  logic       w_enter_walk;
  state_t     w_next_state;
  logic       w_next_ext;
  state_t     w_tgt_state;
  logic       w_tgt_ext;
  logic [1:0] w_tgt_sel;
  logic [2:0] w_tgt_main;
  logic [2:0] w_tgt_side;
  logic       w_tgt_walk;

  // Phase advance on a fresh expiry; an expiry coinciding with our own start
  // pulse belongs to the previous interval and is ignored.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_take       = expired && !r_start_timer;
    w_next_state = r_state;
    w_next_ext   = r_mgx_ext;
    if (w_take) begin
      case (r_state)
        S_MG1: begin
          w_next_state = S_MGX;
          w_next_ext   = sensor;
        end
        S_MGX:   w_next_state = S_MY;
        S_MY:    w_next_state = r_walk_latch ? S_WALK : S_SG;
        S_WALK:  w_next_state = S_SG;
        S_SG:    w_next_state = sensor ? S_SGX : S_SY;
        S_SGX:   w_next_state = S_SY;
        S_SY:    w_next_state = S_MG1;
        default: w_next_state = S_MG1;
      endcase
    end
    w_enter_walk = w_take && (r_state == S_MY) && r_walk_latch;
  end

  // State the registers will hold after this edge, with restarts folded in.
  always_comb begin
    if (Reset || reprogram) begin
      w_tgt_state = S_MG1;
      w_tgt_ext   = 1'b0;
    end else begin
      w_tgt_state = w_next_state;
      w_tgt_ext   = w_next_ext;
    end
  end

  // Moore decode of the target state, so the output registers line up with r_state.
  always_comb begin
    w_tgt_sel  = SEL_BASE;
    w_tgt_main = LIGHT_RED;
    w_tgt_side = LIGHT_RED;
    w_tgt_walk = 1'b0;
    case (w_tgt_state)
      S_MG1: begin
        w_tgt_main = LIGHT_GRN;
      end
      S_MGX: begin
        w_tgt_main = LIGHT_GRN;
        w_tgt_sel  = w_tgt_ext ? SEL_EXT : SEL_BASE;
      end
      S_MY: begin
        w_tgt_main = LIGHT_YEL;
        w_tgt_sel  = SEL_YEL;
      end
      S_WALK: begin
        w_tgt_walk = 1'b1;
        w_tgt_sel  = SEL_EXT;
      end
      S_SG: begin
        w_tgt_side = LIGHT_GRN;
      end
      S_SGX: begin
        w_tgt_side = LIGHT_GRN;
        w_tgt_sel  = SEL_EXT;
      end
      S_SY: begin
        w_tgt_side = LIGHT_YEL;
        w_tgt_sel  = SEL_YEL;
      end
      default: begin
        w_tgt_main = LIGHT_RED;
      end
    endcase
  end

  // Sequencer state, walk latch, timer handshake and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      r_state         <= S_MG1;
      r_mgx_ext       <= 1'b0;
      r_walk_latch    <= 1'b0;
      r_start_pending <= 1'b1;
      r_start_timer   <= 1'b0;
    end else if (reprogram) begin
      // Restart the cycle but keep any pedestrian request already waiting.
      r_state         <= S_MG1;
      r_mgx_ext       <= 1'b0;
      r_walk_latch    <= r_walk_latch | walk_request;
      r_start_pending <= 1'b1;
      r_start_timer   <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_mgx_ext       <= w_next_ext;
      // Entering WALK serves the request, including one arriving this cycle.
      r_walk_latch    <= w_enter_walk ? 1'b0 : (r_walk_latch | walk_request);
      r_start_pending <= 1'b0;
      r_start_timer   <= r_start_pending | w_take;
    end
    r_interval_sel <= w_tgt_sel;
    r_main_lights  <= w_tgt_main;
    r_side_lights  <= w_tgt_side;
    r_walk_lamp    <= w_tgt_walk;
  end

  assign start_timer  = r_start_timer;
  assign interval_sel = r_interval_sel;
  assign main_lights  = r_main_lights;
  assign side_lights  = r_side_lights;
  assign walk_lamp    = r_walk_lamp;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: a behavioural phase model plus
// an interval-timer model drive and predict the controller cycle by cycle.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       sensor = 1'b0;
  logic       walk_request = 1'b0;
  logic       reprogram = 1'b0;
  logic       expired = 1'b0;
  logic       start_timer;
  logic [1:0] interval_sel;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk          (clk),
    .Reset        (Reset),
    .sensor       (sensor),
    .walk_request (walk_request),
    .reprogram    (reprogram),
    .expired      (expired),
    .start_timer  (start_timer),
    .interval_sel (interval_sel),
    .main_lights  (main_lights),
    .side_lights  (side_lights),
    .walk_lamp    (walk_lamp)
  );

  // Reference model: phase of the light cycle plus the bookkeeping the
  // behavioural rules mention (walk latch, owed start pulse, MGX length).
  typedef enum int {P_MG1, P_MGX, P_MY, P_WALK, P_SG, P_SGX, P_SY} phase_e;
  phase_e m_phase  = P_MG1;
  bit     m_ext     = 1'b0;
  bit     m_walk    = 1'b0;
  bit     m_start   = 1'b0;
  bit     m_pending = 1'b0;

  // Interval timer model: loads on start_timer, pulses expired after tmr_delay cycles.
  int tmr_cnt   = 0;
  int tmr_delay = 5;

  // Expected {start_timer, interval_sel, main, side, walk_lamp}.
  function automatic logic [9:0] expect_vec();
    logic [1:0] sel;
    logic [2:0] mn;
    logic [2:0] sd;
    logic       wk;
    sel = 2'b00;
    mn  = 3'b100;
    sd  = 3'b100;
    wk  = 1'b0;
    case (m_phase)
      P_MG1:  mn = 3'b001;
      P_MGX:  begin mn = 3'b001; sel = m_ext ? 2'b01 : 2'b00; end
      P_MY:   begin mn = 3'b010; sel = 2'b10; end
      P_WALK: begin wk = 1'b1; sel = 2'b01; end
      P_SG:   sd = 3'b001;
      P_SGX:  begin sd = 3'b001; sel = 2'b01; end
      P_SY:   begin sd = 3'b010; sel = 2'b10; end
      default: mn = 3'b100;
    endcase
    return {m_start, sel, mn, sd, wk};
  endfunction

  function automatic logic [9:0] observed();
    return {start_timer, interval_sel, main_lights, side_lights, walk_lamp};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle #1.
  task automatic step(input bit rst, input bit rp, input bit wreq, input bit sens,
                      input bit force_exp);
    bit exp_now;
    bit start_now;
    bit take;
    bit go_walk;
    Reset        = rst;
    reprogram    = rp;
    walk_request = wreq;
    sensor       = sens;
    exp_now      = (tmr_cnt == 1) || force_exp;
    expired      = exp_now;
    start_now    = start_timer;
    @(posedge clk);
    take    = exp_now && !m_start;
    go_walk = m_walk;
    if (rst) begin
      m_phase = P_MG1; m_walk = 1'b0; m_start = 1'b0; m_pending = 1'b1; m_ext = 1'b0;
    end else if (rp) begin
      m_phase = P_MG1; m_start = 1'b0; m_pending = 1'b1; m_walk = m_walk | wreq;
    end else begin
      m_start   = m_pending || take;
      m_pending = 1'b0;
      if (take && m_phase == P_MY && go_walk) m_walk = 1'b0;
      else m_walk = m_walk | wreq;
      if (take) begin
        case (m_phase)
          P_MG1:  begin m_phase = P_MGX; m_ext = sens; end
          P_MGX:  m_phase = P_MY;
          P_MY:   if (go_walk) m_phase = P_WALK; else m_phase = P_SG;
          P_WALK: m_phase = P_SG;
          P_SG:   if (sens) m_phase = P_SGX; else m_phase = P_SY;
          P_SGX:  m_phase = P_SY;
          default: m_phase = P_MG1;
        endcase
      end
    end
    if (rst || rp) tmr_cnt = 0;
    else if (start_now) tmr_cnt = tmr_delay;
    else if (tmr_cnt > 0) tmr_cnt--;
    #1;
  endtask

  task automatic test_reset();
    bit reached = 1'b0;
    // Reset held three cycles, with a request and a stale expiry on the first.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, (i == 0), 1'b0, (i == 0));
      if (observed() !== expect_vec()) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got %b want %b", i, observed(), expect_vec());
      end
      checks++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (observed() !== 10'b1_00_001_100_0) begin
      errors++;
      $display("FAIL reset_release got %b want %b", observed(), 10'b1_00_001_100_0);
    end
    checks++;
    for (int i = 0; i < 20 && !reached; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (observed() !== expect_vec()) begin
        errors++;
        $display("FAIL reset_to_mgx cyc%0d got %b want %b", i, observed(), expect_vec());
      end
      checks++;
      reached = (m_phase == P_MGX);
    end
    if (!reached || start_timer !== 1'b1) begin
      errors++;
      $display("FAIL reset_mgx_entry got reached=%0b start=%b want 1 1", reached, start_timer);
    end
    checks++;
  endtask

  // Step until the model sits in the first cycle of MG1; returns whether it got there.
  task automatic align_mg1(input bit sens, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step(1'b0, 1'b0, 1'b0, sens, 1'b0);
      ok = (m_phase == P_MG1) && m_start;
    end
  endtask

  task automatic test_cycle(input bit sens, input string name);
    logic [1:0] sels[$];
    logic [1:0] want[$];
    bit ok;
    bit done = 1'b0;
    int lamp = 0;
    align_mg1(sens, ok);
    if (!ok) begin
      errors++;
      $display("FAIL %s_align got timeout want MG1", name);
    end
    checks++;
    sels.push_back(interval_sel);
    if (sens) want = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    else want = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10};
    for (int i = 0; i < 200 && !done; i++) begin
      step(1'b0, 1'b0, 1'b0, sens, 1'b0);
      if (observed() !== expect_vec()) begin
        errors++;
        $display("FAIL %s cyc%0d got %b want %b", name, i, observed(), expect_vec());
      end
      checks++;
      if (sens && (m_phase == P_SG || m_phase == P_SGX) && side_lights !== 3'b001) begin
        errors++;
        $display("FAIL %s_side_green got %b want 001", name, side_lights);
      end
      if (walk_lamp === 1'b1) lamp++;
      done = (m_phase == P_MG1) && m_start;
      if (start_timer === 1'b1 && !done) sels.push_back(interval_sel);
    end
    if (sels != want) begin
      errors++;
      $display("FAIL %s_sequence got %0d pulses %p want %p", name, sels.size(), sels, want);
    end
    checks++;
    if (lamp != 0) begin
      errors++;
      $display("FAIL %s_walk_lamp got %0d cycles want 0", name, lamp);
    end
    checks++;
  endtask

  task automatic test_walk();
    bit reached = 1'b0;
    int entries = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reached = (m_phase == P_SG);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (observed() !== expect_vec()) begin
        errors++;
        $display("FAIL walk cyc%0d got %b want %b", i, observed(), expect_vec());
      end
      checks++;
      if (walk_lamp === 1'b1 && (main_lights !== 3'b100 || side_lights !== 3'b100)) begin
        errors++;
        $display("FAIL walk_all_red got %b/%b want 100/100", main_lights, side_lights);
      end
      if (walk_lamp === 1'b1 && prev !== 1'b1) entries++;
      prev = walk_lamp;
    end
    if (entries != 1) begin
      errors++;
      $display("FAIL walk_entries got %0d want 1", entries);
    end
    checks++;
  endtask

  task automatic test_stale_and_reprogram();
    bit reached = 1'b0;
    bit seen = 1'b0;
    // A stale expiry in the start-pulse cycle must not move the phase.
    for (int i = 0; i < 100 && !reached; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      reached = (m_phase == P_SG) && m_start;
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    if (observed() !== 10'b0_00_100_001_0) begin
      errors++;
      $display("FAIL stale_expired got %b want %b", observed(), 10'b0_00_100_001_0);
    end
    checks++;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      reached = (m_phase == P_SGX);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    if (observed() !== 10'b0_00_001_100_0) begin
      errors++;
      $display("FAIL reprogram_restart got %b want %b", observed(), 10'b0_00_001_100_0);
    end
    checks++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (observed() !== 10'b1_00_001_100_0) begin
      errors++;
      $display("FAIL reprogram_pulse got %b want %b", observed(), 10'b1_00_001_100_0);
    end
    checks++;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (observed() !== expect_vec()) begin
        errors++;
        $display("FAIL reprogram_run cyc%0d got %b want %b", i, observed(), expect_vec());
      end
      checks++;
      seen = (walk_lamp === 1'b1);
    end
    if (!seen) begin
      errors++;
      $display("FAIL reprogram_latch_kept got no walk want walk");
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int lamp = 0;
    for (int i = 0; i < 23; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    if (observed() !== 10'b0_00_001_100_0) begin
      errors++;
      $display("FAIL reset_mid got %b want %b", observed(), 10'b0_00_001_100_0);
    end
    checks++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (start_timer !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold got %b want 0", start_timer);
    end
    checks++;
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (observed() !== expect_vec()) begin
        errors++;
        $display("FAIL reset_mid_run cyc%0d got %b want %b", i, observed(), expect_vec());
      end
      checks++;
      if (walk_lamp === 1'b1) lamp++;
    end
    if (lamp != 0) begin
      errors++;
      $display("FAIL reset_mid_latch got %0d walk cycles want 0", lamp);
    end
    checks++;
  endtask

  task automatic test_random();
    bit sens = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tmr_delay = $urandom_range(2, 7);
      if ($urandom_range(0, 9) == 0) sens = ~sens;
      step(1'b0, ($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0), sens,
           ($urandom_range(0, 49) == 0));
      if (observed() !== expect_vec()) begin
        errors++;
        $display("FAIL random cyc%0d got %b want %b", i, observed(), expect_vec());
      end
      checks++;
      if ($countones(main_lights) != 1 || $countones(side_lights) != 1 ||
          (main_lights !== 3'b100 && side_lights !== 3'b100)) begin
        errors++;
        $display("FAIL safety cyc%0d got %b/%b want one-hot, one red", i, main_lights, side_lights);
      end
      checks++;
    end
    tmr_delay = 5;
  endtask

  initial begin
    test_reset();
    test_cycle(1'b0, "no_sensor");
    test_cycle(1'b1, "sensor");
    test_walk();
    test_stale_and_reprogram();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
